// File: rtl/tennis_match_scorer.sv
// Tennis match scorer: points, games, sets and tiebreaks with one-cycle completion pulses.
// Define NO_AD_SCORING_EN for no-advantage scoring (the point after deuce decides the game).
module tennis_match_scorer #(
    parameter  int GAMES_PER_SET = 6,
    parameter  int SETS_TO_WIN   = 2,
    parameter  int TB_POINTS     = 7,
    localparam int TW = $clog2(TB_POINTS + 1),
    localparam int GW = $clog2(GAMES_PER_SET + 2),
    localparam int SW = $clog2(SETS_TO_WIN + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    input  logic          p1_point,
    input  logic          p2_point,
    output logic [2:0]    game_state,
    output logic [1:0]    p1_pts,
    output logic [1:0]    p2_pts,
    output logic [TW-1:0] tb_p1,
    output logic [TW-1:0] tb_p2,
    output logic [GW-1:0] p1_games,
    output logic [GW-1:0] p2_games,
    output logic [SW-1:0] p1_sets,
    output logic [SW-1:0] p2_sets,
    output logic          game_win,
    output logic          set_win,
    output logic          match_win,
    output logic          winner
);

    typedef enum logic [2:0] {
        NORMAL     = 3'd0,
        DEUCE      = 3'd1,
        ADV_P1     = 3'd2,
        ADV_P2     = 3'd3,
        TIEBREAK   = 3'd4,
        MATCH_OVER = 3'd5
    } state_t;

    state_t        state, state_nxt;
    logic [1:0]    p1_pts_nxt, p2_pts_nxt;
    logic [TW-1:0] tb_p1_nxt, tb_p2_nxt;
    logic [GW-1:0] p1_games_nxt, p2_games_nxt;
    logic [SW-1:0] p1_sets_nxt, p2_sets_nxt;
    logic          game_win_nxt, set_win_nxt, match_win_nxt, winner_nxt;
    // Set after a tiebreak win: clear games and credit the set on the following edge.
    logic          tb_hold, tb_hold_nxt;

    logic valid, who, do_game, tb_win;
    int   pts_s, pts_o, tb_s, tb_o, g_s, g_o, sets_s;

    assign game_state = state;

    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            state     <= NORMAL;
            p1_pts    <= '0;
            p2_pts    <= '0;
            tb_p1     <= '0;
            tb_p2     <= '0;
            p1_games  <= '0;
            p2_games  <= '0;
            p1_sets   <= '0;
            p2_sets   <= '0;
            game_win  <= 1'b0;
            set_win   <= 1'b0;
            match_win <= 1'b0;
            winner    <= 1'b0;
            tb_hold   <= 1'b0;
        end else begin
            state     <= state_nxt;
            p1_pts    <= p1_pts_nxt;
            p2_pts    <= p2_pts_nxt;
            tb_p1     <= tb_p1_nxt;
            tb_p2     <= tb_p2_nxt;
            p1_games  <= p1_games_nxt;
            p2_games  <= p2_games_nxt;
            p1_sets   <= p1_sets_nxt;
            p2_sets   <= p2_sets_nxt;
            game_win  <= game_win_nxt;
            set_win   <= set_win_nxt;
            match_win <= match_win_nxt;
            winner    <= winner_nxt;
            tb_hold   <= tb_hold_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        p1_pts_nxt    = p1_pts;
        p2_pts_nxt    = p2_pts;
        tb_p1_nxt     = tb_p1;
        tb_p2_nxt     = tb_p2;
        p1_games_nxt  = p1_games;
        p2_games_nxt  = p2_games;
        p1_sets_nxt   = p1_sets;
        p2_sets_nxt   = p2_sets;
        game_win_nxt  = 1'b0;
        set_win_nxt   = 1'b0;
        match_win_nxt = 1'b0;
        winner_nxt    = winner;
        tb_hold_nxt   = 1'b0;
        do_game       = 1'b0;
        tb_win        = 1'b0;

        valid  = p1_point ^ p2_point;
        who    = p2_point;
        pts_s  = who ? int'(p2_pts) : int'(p1_pts);
        pts_o  = who ? int'(p1_pts) : int'(p2_pts);
        tb_s   = (who ? int'(tb_p2) : int'(tb_p1)) + 1;
        tb_o   = who ? int'(tb_p1) : int'(tb_p2);
        g_s    = (who ? int'(p2_games) : int'(p1_games)) + 1;
        g_o    = who ? int'(p1_games) : int'(p2_games);
        sets_s = (who ? int'(p2_sets) : int'(p1_sets)) + 1;

        if (tb_hold) begin
            p1_games_nxt = '0;
            p2_games_nxt = '0;
            if (winner) p2_sets_nxt = SW'(int'(p2_sets) + 1);
            else        p1_sets_nxt = SW'(int'(p1_sets) + 1);
        end

        case (state)
            NORMAL: if (valid) begin
                if (pts_s == 3 && pts_o != 3) begin
                    do_game = 1'b1;
                end else if (pts_o == 3 && pts_s >= 2) begin
                    state_nxt  = DEUCE;
                    p1_pts_nxt = 2'd3;
                    p2_pts_nxt = 2'd3;
                end else if (who) begin
                    p2_pts_nxt = 2'(pts_s + 1);
                end else begin
                    p1_pts_nxt = 2'(pts_s + 1);
                end
            end
            DEUCE: if (valid) begin
`ifdef NO_AD_SCORING_EN
                do_game = 1'b1;
`else
                state_nxt = who ? ADV_P2 : ADV_P1;
`endif
            end
            ADV_P1: if (valid) begin
                if (!who) do_game = 1'b1;
                else      state_nxt = DEUCE;
            end
            ADV_P2: if (valid) begin
                if (who) do_game = 1'b1;
                else     state_nxt = DEUCE;
            end
            TIEBREAK: if (valid) begin
                if (tb_s >= TB_POINTS && tb_s - tb_o >= 2) begin
                    tb_win = 1'b1;
                end else if (tb_s == tb_o && tb_s >= TB_POINTS - 1) begin
                    // Long tiebreaks fold back so the counters stay within TW bits.
                    tb_p1_nxt = TW'(TB_POINTS - 1);
                    tb_p2_nxt = TW'(TB_POINTS - 1);
                end else if (who) begin
                    tb_p2_nxt = TW'(tb_s);
                end else begin
                    tb_p1_nxt = TW'(tb_s);
                end
            end
            MATCH_OVER: ;
            default: begin
                state_nxt    = NORMAL;
                p1_pts_nxt   = '0;
                p2_pts_nxt   = '0;
                tb_p1_nxt    = '0;
                tb_p2_nxt    = '0;
                p1_games_nxt = '0;
                p2_games_nxt = '0;
                p1_sets_nxt  = '0;
                p2_sets_nxt  = '0;
                winner_nxt   = 1'b0;
            end
        endcase

        if (do_game) begin
            state_nxt    = NORMAL;
            p1_pts_nxt   = '0;
            p2_pts_nxt   = '0;
            game_win_nxt = 1'b1;
            winner_nxt   = who;
            if (g_s >= GAMES_PER_SET && g_s - g_o >= 2) begin
                set_win_nxt  = 1'b1;
                p1_games_nxt = '0;
                p2_games_nxt = '0;
                if (who) p2_sets_nxt = SW'(sets_s);
                else     p1_sets_nxt = SW'(sets_s);
                if (sets_s >= SETS_TO_WIN) begin
                    match_win_nxt = 1'b1;
                    state_nxt     = MATCH_OVER;
                end
            end else begin
                if (who) p2_games_nxt = GW'(g_s);
                else     p1_games_nxt = GW'(g_s);
                if (g_s == GAMES_PER_SET && g_o == GAMES_PER_SET) begin
                    state_nxt = TIEBREAK;
                    tb_p1_nxt = '0;
                    tb_p2_nxt = '0;
                end
            end
        end

        if (tb_win) begin
            state_nxt    = NORMAL;
            game_win_nxt = 1'b1;
            set_win_nxt  = 1'b1;
            winner_nxt   = who;
            tb_p1_nxt    = '0;
            tb_p2_nxt    = '0;
            tb_hold_nxt  = 1'b1;
            if (who) p2_games_nxt = GW'(GAMES_PER_SET + 1);
            else     p1_games_nxt = GW'(GAMES_PER_SET + 1);
            if (sets_s >= SETS_TO_WIN) begin
                match_win_nxt = 1'b1;
                state_nxt     = MATCH_OVER;
            end
        end
    end

endmodule

// File: tb/tb_tennis_match_scorer.sv
// Directed bench for tennis_match_scorer at default parameters: vector table plus match sequences.
module tb_tennis_match_scorer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic       p1_point = 1'b0;
    logic       p2_point = 1'b0;
    logic [2:0] game_state;
    logic [1:0] p1_pts, p2_pts;
    logic [2:0] tb_p1, tb_p2;
    logic [2:0] p1_games, p2_games;
    logic [1:0] p1_sets, p2_sets;
    logic       game_win, set_win, match_win, winner;

    int checks = 0;
    int failures = 0;

    tennis_match_scorer dut (
        .clk(clk), .rst_n(rst_n), .clr(clr), .p1_point(p1_point), .p2_point(p2_point),
        .game_state(game_state), .p1_pts(p1_pts), .p2_pts(p2_pts),
        .tb_p1(tb_p1), .tb_p2(tb_p2), .p1_games(p1_games), .p2_games(p2_games),
        .p1_sets(p1_sets), .p2_sets(p2_sets), .game_win(game_win), .set_win(set_win),
        .match_win(match_win), .winner(winner)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] st;
        logic [1:0] p1p, p2p;
        logic [2:0] t1, t2, g1, g2;
        logic [1:0] s1, s2;
        logic       gw, sw, mw, win;
    } out_t;

    typedef struct {
        logic r, c, a, b;
        out_t e;
    } vec_t;

    vec_t vecs[$];

    function automatic out_t ex(input int st, p1p, p2p, t1, t2, g1, g2, s1, s2, gw, sw, mw, win);
        out_t o;
        o.st = 3'(st);   o.p1p = 2'(p1p); o.p2p = 2'(p2p);
        o.t1 = 3'(t1);   o.t2 = 3'(t2);   o.g1 = 3'(g1);   o.g2 = 3'(g2);
        o.s1 = 2'(s1);   o.s2 = 2'(s2);
        o.gw = 1'(gw);   o.sw = 1'(sw);   o.mw = 1'(mw);   o.win = 1'(win);
        return o;
    endfunction

    function automatic vec_t mk(input int r, c, a, b, st, p1p, p2p, g1, g2, gw, win);
        vec_t v;
        v.r = 1'(r); v.c = 1'(c); v.a = 1'(a); v.b = 1'(b);
        v.e = ex(st, p1p, p2p, 0, 0, g1, g2, 0, 0, gw, 0, 0, win);
        return v;
    endfunction

    task automatic step(input logic r, input logic c, input logic a, input logic b);
        rst_n = r; clr = c; p1_point = a; p2_point = b;
        @(posedge clk);
        #1;
        rst_n = 1'b1; clr = 1'b0; p1_point = 1'b0; p2_point = 1'b0;
    endtask

    task automatic game(input logic who);
        for (int k = 0; k < 4; k++) step(1'b1, 1'b0, !who, who);
    endtask

    task automatic compare(input string name, input out_t e);
        checks++;
        if (game_state !== e.st || p1_pts !== e.p1p || p2_pts !== e.p2p || tb_p1 !== e.t1 ||
            tb_p2 !== e.t2 || p1_games !== e.g1 || p2_games !== e.g2 || p1_sets !== e.s1 ||
            p2_sets !== e.s2 || game_win !== e.gw || set_win !== e.sw || match_win !== e.mw ||
            winner !== e.win) begin
            failures++;
            $display("FAIL %s got st=%0d pts=%0d/%0d tb=%0d/%0d g=%0d/%0d s=%0d/%0d gw=%b sw=%b mw=%b win=%b expected st=%0d pts=%0d/%0d tb=%0d/%0d g=%0d/%0d s=%0d/%0d gw=%b sw=%b mw=%b win=%b",
                     name, game_state, p1_pts, p2_pts, tb_p1, tb_p2, p1_games, p2_games, p1_sets, p2_sets,
                     game_win, set_win, match_win, winner, e.st, e.p1p, e.p2p, e.t1, e.t2, e.g1, e.g2,
                     e.s1, e.s2, e.gw, e.sw, e.mw, e.win);
        end
    endtask

    initial begin
        // r c a b | st p1p p2p g1 g2 gw win
        vecs.push_back(mk(0,0,0,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,2,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,3,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,0,0,1,0,1,0));
        vecs.push_back(mk(1,0,0,0, 0,0,0,1,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,1,0,1,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,2,0,1,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,3,0,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,3,1,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,3,2,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 1,3,3,1,0,0,0));
`ifndef NO_AD_SCORING_EN
        vecs.push_back(mk(1,0,1,0, 2,3,3,1,0,0,0));
        vecs.push_back(mk(1,0,0,1, 1,3,3,1,0,0,0));
        vecs.push_back(mk(1,0,1,0, 2,3,3,1,0,0,0));
`endif
        vecs.push_back(mk(1,0,1,0, 0,0,0,2,0,1,0));
        vecs.push_back(mk(1,0,0,1, 0,0,1,2,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,2,2,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,3,2,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,0,0,2,1,1,1));
        vecs.push_back(mk(1,0,0,0, 0,0,0,2,1,0,1));
        vecs.push_back(mk(1,0,1,0, 0,1,0,2,1,0,1));
        vecs.push_back(mk(1,0,1,0, 0,2,0,2,1,0,1));
        vecs.push_back(mk(1,0,0,1, 0,2,1,2,1,0,1));
        vecs.push_back(mk(1,0,0,1, 0,2,2,2,1,0,1));
        vecs.push_back(mk(1,0,1,1, 0,2,2,2,1,0,1));
        vecs.push_back(mk(1,1,1,0, 0,0,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,1,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,2,0,0,0,0,0));
        vecs.push_back(mk(1,0,1,0, 0,3,0,0,0,0,0));
        vecs.push_back(mk(1,0,0,1, 0,3,1,0,0,0,0));
        vecs.push_back(mk(0,0,0,1, 0,0,0,0,0,0,0));

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].r, vecs[i].c, vecs[i].a, vecs[i].b);
            compare($sformatf("vec%0d", i), vecs[i].e);
        end

        // 6-5 continues, 7-5 takes the set
        step(0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            game(0); game(1);
            compare($sformatf("set75_%0d", i), ex(0,0,0,0,0,i+1,i+1,0,0,1,0,0,1));
        end
        game(0); compare("set75_6_5", ex(0,0,0,0,0,6,5,0,0,1,0,0,0));
        game(0); compare("set75_7_5", ex(0,0,0,0,0,0,0,1,0,1,1,0,0));

        // tiebreak won 8-6 by P2 after a 7-7 fold
        step(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) begin
            game(0); game(1);
            compare($sformatf("tbg_%0d", i), ex((i == 5) ? 4 : 0,0,0,0,0,i+1,i+1,0,0,1,0,0,1));
        end
        for (int i = 0; i < 7; i++) begin
            step(1, 0, 1, 0); step(1, 0, 0, 1);
            compare($sformatf("tbp_%0d", i),
                    ex(4,0,0,(i+1 > 6) ? 6 : i+1,(i+1 > 6) ? 6 : i+1,6,6,0,0,0,0,0,1));
        end
        step(1, 0, 0, 1); compare("tb_6_7", ex(4,0,0,6,7,6,6,0,0,0,0,0,1));
        step(1, 0, 0, 1); compare("tb_win", ex(0,0,0,0,0,6,7,0,0,1,1,0,1));
        step(1, 0, 1, 0); compare("tb_after", ex(0,1,0,0,0,0,0,0,1,0,0,0,1));

        // straight-sets match for P1
        step(0, 0, 0, 0);
        for (int i = 0; i < 12; i++) begin
            game(0);
            if (i == 5)       compare("m_set1", ex(0,0,0,0,0,0,0,1,0,1,1,0,0));
            else if (i == 11) compare("m_match", ex(5,0,0,0,0,0,0,2,0,1,1,1,0));
            else compare($sformatf("m_g%0d", i),
                         ex(0,0,0,0,0,(i < 5) ? i+1 : i-5,0,(i < 5) ? 0 : 1,0,1,0,0,0));
        end
        step(1, 0, 0, 1); compare("m_over_p2", ex(5,0,0,0,0,0,0,2,0,0,0,0,0));
        step(1, 0, 1, 0); compare("m_over_p1", ex(5,0,0,0,0,0,0,2,0,0,0,0,0));
        for (int k = 0; k < 4; k++) step(1, 0, 0, 1);
        compare("m_over_p2x4", ex(5,0,0,0,0,0,0,2,0,0,0,0,0));
        step(1, 1, 0, 0); compare("m_clr", ex(0,0,0,0,0,0,0,0,0,0,0,0,0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
